// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two cache controllers, the arbiter and main memory.
// The arbiter takes the slave view; caches plus memory model take the master view.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic              I_READ;
  logic [ADDR_W-1:0] I_ADDRESS;
  logic [DATA_W-1:0] I_READDATA;
  logic              I_BUSYWAIT;
  logic              D_READ;
  logic              D_WRITE;
  logic [ADDR_W-1:0] D_ADDRESS;
  logic [DATA_W-1:0] D_WRITEDATA;
  logic [DATA_W-1:0] D_READDATA;
  logic              D_BUSYWAIT;
  logic              MEM_READ;
  logic              MEM_WRITE;
  logic [ADDR_W-1:0] MEM_ADDRESS;
  logic [DATA_W-1:0] MEM_WRITEDATA;
  logic [DATA_W-1:0] MEM_READDATA;
  logic              MEM_BUSYWAIT;
  logic              ERROR;

  modport slave (
    input  I_READ, I_ADDRESS, D_READ, D_WRITE, D_ADDRESS, D_WRITEDATA,
           MEM_READDATA, MEM_BUSYWAIT,
    output I_READDATA, I_BUSYWAIT, D_READDATA, D_BUSYWAIT,
           MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA, ERROR
  );

  modport master (
    output I_READ, I_ADDRESS, D_READ, D_WRITE, D_ADDRESS, D_WRITEDATA,
           MEM_READDATA, MEM_BUSYWAIT,
    input  I_READDATA, I_BUSYWAIT, D_READDATA, D_BUSYWAIT,
           MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA, ERROR
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one main-memory block port between the I-cache and D-cache,
// sequencing IDLE -> ISSUE -> WAIT -> DONE with a WAIT timeout that sets a sticky ERROR.
module mem_bus_arbiter #(
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               CLK,
  input  logic               RESET,
  mem_bus_arbiter_if.slave   bus
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              error_q, error_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              i_req_s, d_req_s, grant_d_s;

  assign i_req_s   = bus.I_READ;
  assign d_req_s   = bus.D_READ | bus.D_WRITE;
  // D wins only when I is idle or I was served last
  assign grant_d_s = d_req_s & (~i_req_s | (last_grant_q == OWN_I));

  // State register and latched access copies
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= IDLE;
      owner_q      <= OWN_D;
      last_grant_q <= OWN_D;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      addr_q       <= {ADDR_W{1'b0}};
      wdata_q      <= {DATA_W{1'b0}};
      i_rdata_q    <= {DATA_W{1'b0}};
      d_rdata_q    <= {DATA_W{1'b0}};
      error_q      <= 1'b0;
      cnt_q        <= {CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      error_q      <= error_d;
      cnt_q        <= cnt_d;
    end
  end

  // Next-state, grant and data-capture logic
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    error_d      = error_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if (i_req_s || d_req_s) begin
          owner_d      = grant_d_s;
          last_grant_d = grant_d_s;
          cnt_d        = {CNT_W{1'b0}};
          state_d      = ISSUE;
          if (grant_d_s) begin
            // a simultaneous read+write from D is carried out as a write
            addr_d      = bus.D_ADDRESS;
            wdata_d     = bus.D_WRITEDATA;
            mem_write_d = bus.D_WRITE;
            mem_read_d  = ~bus.D_WRITE;
          end else begin
            addr_d      = bus.I_ADDRESS;
            wdata_d     = {DATA_W{1'b0}};
            mem_write_d = 1'b0;
            mem_read_d  = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (!bus.MEM_BUSYWAIT) begin
          if (mem_read_q) begin
            if (owner_q == OWN_D) begin
              d_rdata_d = bus.MEM_READDATA;
            end else begin
              i_rdata_d = bus.MEM_READDATA;
            end
          end else begin
            d_rdata_d = d_rdata_q;
          end
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          cnt_d       = {CNT_W{1'b0}};
          state_d     = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          error_d = 1'b1;
          if (owner_q == OWN_D) begin
            d_rdata_d = {DATA_W{1'b0}};
          end else begin
            i_rdata_d = {DATA_W{1'b0}};
          end
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          cnt_d       = {CNT_W{1'b0}};
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.MEM_READ      = mem_read_q;
  assign bus.MEM_WRITE     = mem_write_q;
  assign bus.MEM_ADDRESS   = addr_q;
  assign bus.MEM_WRITEDATA = wdata_q;
  assign bus.I_READDATA    = i_rdata_q;
  assign bus.D_READDATA    = d_rdata_q;
  assign bus.ERROR         = error_q;
  // each requester is released only during its own DONE cycle
  assign bus.I_BUSYWAIT    = i_req_s & ~((state_q == DONE) & (owner_q == OWN_I));
  assign bus.D_BUSYWAIT    = d_req_s & ~((state_q == DONE) & (owner_q == OWN_D));
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: stimulus queues expected grants and completions,
// negedge monitors compare them against the bus; a 5-cycle busy memory model sits behind it.
module tb_mem_bus_arbiter;
  logic clk;
  logic rst;
  logic hang;
  int   n_vec;
  int   n_err;

  typedef struct packed {
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] wd;
  } grant_t;

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
  } comp_t;

  grant_t gq[$];
  comp_t  iq[$];
  comp_t  dq[$];

  logic [31:0] mem [64];
  logic        mbusy;
  logic [2:0]  mcnt;
  logic        mprev;

  logic [5:0]  r_i_addr [4] = '{6'h01, 6'h05, 6'h02, 6'h3F};
  logic [31:0] r_i_exp  [4] = '{32'hC0DE0001, 32'hA1B2C3D4, 32'h55667788, 32'h11223344};
  logic        r_d_wr   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [5:0]  r_d_addr [4] = '{6'h3F, 6'h02, 6'h01, 6'h03};
  logic [31:0] r_d_wd   [4] = '{32'h0, 32'h55667788, 32'h0, 32'h99AABBCC};
  logic [31:0] r_d_exp  [4] = '{32'h11223344, 32'h11223344, 32'hC0DE0001, 32'hC0DE0001};

  mem_bus_arbiter_if #(.ADDR_W(6), .DATA_W(32)) bus ();

  mem_bus_arbiter #(.ADDR_W(6), .DATA_W(32), .TIMEOUT(255)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: busy for 5 cycles after a rising strobe, or forever while hang is set
  always @(posedge clk) begin
    if (rst) begin
      mbusy <= 1'b0;
      mcnt  <= 3'd0;
      mprev <= 1'b0;
      for (int i = 0; i < 64; i++)
        mem[i] <= (i == 5) ? 32'hA1B2C3D4 : (32'hC0DE0000 + 32'(i));
    end else begin
      mprev <= bus.MEM_READ | bus.MEM_WRITE;
      if ((bus.MEM_READ | bus.MEM_WRITE) && !mprev && !mbusy) begin
        mbusy <= 1'b1;
        mcnt  <= 3'd5;
        if (bus.MEM_WRITE) mem[bus.MEM_ADDRESS] <= bus.MEM_WRITEDATA;
      end else if (mbusy && !hang) begin
        if (!(bus.MEM_READ | bus.MEM_WRITE) || mcnt == 3'd1) mbusy <= 1'b0;
        else mcnt <= mcnt - 3'd1;
      end
    end
  end

  assign bus.MEM_READDATA = mem[bus.MEM_ADDRESS];
  assign bus.MEM_BUSYWAIT = mbusy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Grant monitor: every new memory strobe must match the next expected grant
  initial begin
    logic prev_s;
    grant_t g;
    prev_s = 1'b0;
    forever begin
      @(negedge clk);
      if ((bus.MEM_READ | bus.MEM_WRITE) && !prev_s) begin
        if (gq.size() == 0) begin
          chk("unexpected_grant", {26'd0, bus.MEM_ADDRESS}, 32'hFFFFFFFF);
        end else begin
          g = gq.pop_front();
          chk("grant_addr", {26'd0, bus.MEM_ADDRESS}, {26'd0, g.addr});
          chk("grant_op", {30'd0, bus.MEM_WRITE, bus.MEM_READ}, {30'd0, g.wr, ~g.wr});
          if (g.wr) chk("grant_wdata", bus.MEM_WRITEDATA, g.wd);
        end
      end
      prev_s = bus.MEM_READ | bus.MEM_WRITE;
    end
  end

  // Completion monitor: a released requester must see the expected block and ERROR
  initial begin
    comp_t c;
    forever begin
      @(negedge clk);
      if (bus.I_READ && !bus.I_BUSYWAIT) begin
        if (iq.size() == 0) begin
          chk("unexpected_i_done", bus.I_READDATA, 32'hFFFFFFFF);
        end else begin
          c = iq.pop_front();
          chk("i_readdata", bus.I_READDATA, c.rd);
          chk("i_error", {31'd0, bus.ERROR}, {31'd0, c.err});
        end
      end
      if ((bus.D_READ | bus.D_WRITE) && !bus.D_BUSYWAIT) begin
        if (dq.size() == 0) begin
          chk("unexpected_d_done", bus.D_READDATA, 32'hFFFFFFFF);
        end else begin
          c = dq.pop_front();
          chk("d_readdata", bus.D_READDATA, c.rd);
          chk("d_error", {31'd0, bus.ERROR}, {31'd0, c.err});
        end
      end
    end
  end

  // One requester access: raise, wait for release (bounded), drop during DONE
  task automatic req(input bit is_d, input bit wr, input logic [5:0] a, input logic [31:0] wd,
                     input logic [31:0] erd, input bit eerr, input int elat);
    int n;
    bit done;
    if (is_d) dq.push_back('{rd: erd, err: eerr});
    else      iq.push_back('{rd: erd, err: eerr});
    @(posedge clk);
    #1;
    if (is_d) begin
      bus.D_ADDRESS   = a;
      bus.D_WRITEDATA = wd;
      bus.D_WRITE     = wr;
      bus.D_READ      = ~wr;
    end else begin
      bus.I_ADDRESS = a;
      bus.I_READ    = 1'b1;
    end
    n    = 0;
    done = 1'b0;
    while (!done && n < 400) begin
      @(negedge clk);
      if (is_d ? !bus.D_BUSYWAIT : !bus.I_BUSYWAIT) done = 1'b1;
      else n++;
    end
    #1;
    if (is_d) begin
      bus.D_READ  = 1'b0;
      bus.D_WRITE = 1'b0;
    end else begin
      bus.I_READ = 1'b0;
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL req_timeout: got no release after %0d cycles expected release", n);
    end else if (elat >= 0) begin
      chk(is_d ? "d_latency" : "i_latency", 32'(n), 32'(elat));
    end
  endtask

  task automatic check_reset();
    chk("rst_mem_read", {31'd0, bus.MEM_READ}, 32'd0);
    chk("rst_mem_write", {31'd0, bus.MEM_WRITE}, 32'd0);
    chk("rst_mem_address", {26'd0, bus.MEM_ADDRESS}, 32'd0);
    chk("rst_mem_writedata", bus.MEM_WRITEDATA, 32'd0);
    chk("rst_i_readdata", bus.I_READDATA, 32'd0);
    chk("rst_d_readdata", bus.D_READDATA, 32'd0);
    chk("rst_error", {31'd0, bus.ERROR}, 32'd0);
    chk("rst_busywaits", {30'd0, bus.I_BUSYWAIT, bus.D_BUSYWAIT}, 32'd0);
  endtask

  task automatic do_reset(input int ncyc);
    @(posedge clk);
    #1;
    rst         = 1'b1;
    bus.I_READ  = 1'b0;
    bus.D_READ  = 1'b0;
    bus.D_WRITE = 1'b0;
    repeat (ncyc) @(posedge clk);
    @(negedge clk);
    check_reset();
    rst = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec           = 0;
    n_err           = 0;
    rst             = 1'b1;
    hang            = 1'b0;
    bus.I_READ      = 1'b0;
    bus.I_ADDRESS   = 6'h00;
    bus.D_READ      = 1'b0;
    bus.D_WRITE     = 1'b0;
    bus.D_ADDRESS   = 6'h00;
    bus.D_WRITEDATA = 32'h0;

    // 1. reset
    do_reset(2);

    // 2. single I read, released in the 9th cycle after the request
    gq.push_back('{wr: 1'b0, addr: 6'h05, wd: 32'h0});
    req(1'b0, 1'b0, 6'h05, 32'h0, 32'hA1B2C3D4, 1'b0, 8);

    // 3. simultaneous after reset: I first, D write next
    do_reset(2);
    gq.push_back('{wr: 1'b0, addr: 6'h10, wd: 32'h0});
    gq.push_back('{wr: 1'b1, addr: 6'h3F, wd: 32'h11223344});
    fork
      req(1'b0, 1'b0, 6'h10, 32'h0, 32'hC0DE0010, 1'b0, 8);
      req(1'b1, 1'b1, 6'h3F, 32'h11223344, 32'h0, 1'b0, 17);
    join

    // 4. four contested rounds alternate I, D
    for (int r = 0; r < 4; r++) begin
      gq.push_back('{wr: 1'b0, addr: r_i_addr[r], wd: 32'h0});
      gq.push_back('{wr: r_d_wr[r], addr: r_d_addr[r], wd: r_d_wd[r]});
      fork
        req(1'b0, 1'b0, r_i_addr[r], 32'h0, r_i_exp[r], 1'b0, 8);
        req(1'b1, r_d_wr[r], r_d_addr[r], r_d_wd[r], r_d_exp[r], 1'b0, 17);
      join
    end

    // 5. memory never answers: abort with ERROR, then a normal access keeps ERROR sticky
    hang = 1'b1;
    gq.push_back('{wr: 1'b0, addr: 6'h22, wd: 32'h0});
    req(1'b0, 1'b0, 6'h22, 32'h0, 32'h0, 1'b1, -1);
    hang = 1'b0;
    gq.push_back('{wr: 1'b0, addr: 6'h04, wd: 32'h0});
    req(1'b0, 1'b0, 6'h04, 32'h0, 32'hC0DE0004, 1'b1, 8);

    // 6. reset in the middle of WAIT, then the request completes normally
    gq.push_back('{wr: 1'b0, addr: 6'h10, wd: 32'h0});
    @(posedge clk);
    #1;
    bus.D_ADDRESS = 6'h10;
    bus.D_READ    = 1'b1;
    repeat (4) @(posedge clk);
    do_reset(1);
    gq.push_back('{wr: 1'b0, addr: 6'h10, wd: 32'h0});
    req(1'b1, 1'b0, 6'h10, 32'h0, 32'hC0DE0010, 1'b0, 8);

    repeat (3) @(negedge clk);
    chk("grants_left", 32'(gq.size()), 32'd0);
    chk("i_done_left", 32'(iq.size()), 32'd0);
    chk("d_done_left", 32'(dq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
